// File: rtl/tl_protocol_checker.sv
// Passive TileLink A/C/D/E protocol checker: burst stability, request/response pairing, watchdog.
// Define TL_CHECKER_PRINT_EN to get a simulation-only $display trace of first beats and errors.

module tl_burst_track #(
  parameter int FIELD_W  = 8,
  parameter int LG_BYTES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic               is_data,
  input  logic [3:0]         size,
  input  logic [FIELD_W-1:0] fields,
  output logic               first,
  output logic               last,
  output logic               burst_err,
  output logic [FIELD_W-1:0] msg
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [3:0] LG = 4'(LG_BYTES);

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic [7:0]         last_idx, last_idx_n;
  logic [FIELD_W-1:0] held, held_n;
  logic               multi;
  logic [7:0]         span;

  always_comb begin
    multi = is_data && (size > LG);
    span  = '0;
    if (multi) span = 8'((16'd1 << (size - LG)) - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_idx <= '0;
      held     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_idx <= last_idx_n;
      held     <= held_n;
    end
  end

  // In a burst the latched first beat stands in for the message fields.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_idx_n = last_idx;
    held_n     = held;
    first      = 1'b0;
    last       = 1'b0;
    burst_err  = 1'b0;
    msg        = (state == IDLE) ? fields : held;
    case (state)
      IDLE: begin
        if (fire) begin
          first  = 1'b1;
          held_n = fields;
          if (multi) begin
            state_n    = BURST;
            cnt_n      = 8'd1;
            last_idx_n = span;
          end else begin
            last = 1'b1;
          end
        end
      end
      BURST: begin
        if (fire) begin
          burst_err = (fields != held);
          if (cnt == last_idx) begin
            last    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

module tl_protocol_checker #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 4,
  parameter int SINK_W   = 4,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                c_valid,
  input  logic                c_ready,
  input  logic [2:0]          c_opcode,
  input  logic [3:0]          c_size,
  input  logic [SOURCE_W-1:0] c_source,
  input  logic [ADDR_W-1:0]   c_address,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [3:0]          d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SINK_W-1:0]   d_sink,
  input  logic                e_valid,
  input  logic                e_ready,
  input  logic [SINK_W-1:0]   e_sink,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    a_req_count,
  output logic [CNT_W-1:0]    d_rsp_count,
  output logic [SOURCE_W:0]   outstanding
);

  localparam int LG_BYTES = $clog2(DATA_W / 8);
  localparam int NSRC     = 2 ** SOURCE_W;
  localparam int NSNK     = 2 ** SINK_W;
  localparam int AF_W     = 7 + SOURCE_W + ADDR_W;
  localparam int DF_W     = 7 + SOURCE_W + SINK_W;
  localparam int WD_W     = $clog2(TIMEOUT + 1);

  localparam logic [WD_W-1:0]  WD_ONE  = 1;
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] E_BURST    = 3'd1;
  localparam logic [2:0] E_DUP_SRC  = 3'd2;
  localparam logic [2:0] E_NO_REQ   = 3'd3;
  localparam logic [2:0] E_BAD_SINK = 3'd4;
  localparam logic [2:0] E_TIMEOUT  = 3'd5;

  logic a_fire, c_fire, d_fire, e_fire;
  logic a_first, a_berr, c_first, c_berr, d_first, d_last, d_berr;
  logic a_last_unused, c_last_unused;
  logic [AF_W-1:0] a_msg_unused, c_msg_unused;
  logic [DF_W-1:0] d_msg;
  logic [2:0]          d_op_m;
  logic [3:0]          d_size_unused;
  logic [SOURCE_W-1:0] d_src_m;
  logic [SINK_W-1:0]   d_sink_m;

  logic [NSRC-1:0] a_pend, a_pend_n, a_set, a_clr;
  logic [NSRC-1:0] r_pend, r_pend_n, r_set, r_clr;
  logic [NSNK-1:0] g_pend, g_pend_n, g_set, g_clr;
  logic [WD_W-1:0] wd, wd_inc;
  logic e_burst, e_dup, e_noreq, e_bad, e_tmo, any_err;
  logic [2:0] code;

  assign a_fire = a_valid & a_ready;
  assign c_fire = c_valid & c_ready;
  assign d_fire = d_valid & d_ready;
  assign e_fire = e_valid & e_ready;

  tl_burst_track #(.FIELD_W(AF_W), .LG_BYTES(LG_BYTES)) u_a (
    .clk(clk), .rst(rst), .fire(a_fire), .is_data(a_opcode <= 3'd3), .size(a_size),
    .fields({a_opcode, a_size, a_source, a_address}),
    .first(a_first), .last(a_last_unused), .burst_err(a_berr), .msg(a_msg_unused)
  );

  tl_burst_track #(.FIELD_W(AF_W), .LG_BYTES(LG_BYTES)) u_c (
    .clk(clk), .rst(rst), .fire(c_fire),
    .is_data((c_opcode == 3'd1) || (c_opcode == 3'd5) || (c_opcode == 3'd7)), .size(c_size),
    .fields({c_opcode, c_size, c_source, c_address}),
    .first(c_first), .last(c_last_unused), .burst_err(c_berr), .msg(c_msg_unused)
  );

  tl_burst_track #(.FIELD_W(DF_W), .LG_BYTES(LG_BYTES)) u_d (
    .clk(clk), .rst(rst), .fire(d_fire),
    .is_data((d_opcode == 3'd1) || (d_opcode == 3'd5)), .size(d_size),
    .fields({d_opcode, d_size, d_source, d_sink}),
    .first(d_first), .last(d_last), .burst_err(d_berr), .msg(d_msg)
  );

  assign {d_op_m, d_size_unused, d_src_m, d_sink_m} = d_msg;

  // Clears are computed before sets so a same-cycle clear+set on one index nets to set, without E_DUP_SRC.
  always_comb begin
    a_set   = '0;
    a_clr   = '0;
    r_set   = '0;
    r_clr   = '0;
    g_set   = '0;
    g_clr   = '0;
    e_dup   = 1'b0;
    e_noreq = 1'b0;
    e_bad   = 1'b0;
    e_burst = a_berr | c_berr | d_berr;
    if (d_last) begin
      if (d_op_m == 3'd6) begin
        if (!r_pend[d_src_m]) e_noreq = 1'b1;
        r_clr[d_src_m] = 1'b1;
      end else begin
        if (!a_pend[d_src_m]) e_noreq = 1'b1;
        a_clr[d_src_m] = 1'b1;
        if ((d_op_m == 3'd4) || (d_op_m == 3'd5)) g_set[d_sink_m] = 1'b1;
      end
    end
    if (a_first) begin
      if (a_pend[a_source] && !a_clr[a_source]) e_dup = 1'b1;
      a_set[a_source] = 1'b1;
    end
    if (c_first && ((c_opcode == 3'd6) || (c_opcode == 3'd7))) r_set[c_source] = 1'b1;
    if (e_fire) begin
      if (!g_pend[e_sink]) e_bad = 1'b1;
      g_clr[e_sink] = 1'b1;
    end
    a_pend_n = (a_pend & ~a_clr) | a_set;
    r_pend_n = (r_pend & ~r_clr) | r_set;
    g_pend_n = (g_pend & ~g_clr) | g_set;
  end

  always_comb begin
    wd_inc  = wd + WD_ONE;
    e_tmo   = (a_pend != '0) && !d_fire && (wd_inc == WD_MAX);
    any_err = e_burst | e_dup | e_noreq | e_bad | e_tmo;
    if (e_burst)      code = E_BURST;
    else if (e_dup)   code = E_DUP_SRC;
    else if (e_noreq) code = E_NO_REQ;
    else if (e_bad)   code = E_BAD_SINK;
    else if (e_tmo)   code = E_TIMEOUT;
    else              code = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pend      <= '0;
      r_pend      <= '0;
      g_pend      <= '0;
      wd          <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      a_req_count <= '0;
      d_rsp_count <= '0;
    end else begin
      a_pend     <= a_pend_n;
      r_pend     <= r_pend_n;
      g_pend     <= g_pend_n;
      err_valid  <= any_err;
      err_sticky <= err_sticky | any_err;
      if (d_fire || (a_pend == '0) || e_tmo) wd <= '0;
      else wd <= wd_inc;
      if (any_err) err_code <= code;
      if (any_err && (err_count != '1)) err_count <= err_count + CNT_ONE;
      if (a_first && (a_req_count != '1)) a_req_count <= a_req_count + CNT_ONE;
      if (d_last && (d_rsp_count != '1)) d_rsp_count <= d_rsp_count + CNT_ONE;
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NSRC; i++) outstanding = outstanding + (SOURCE_W + 1)'(a_pend[i]);
  end

`ifdef TL_CHECKER_PRINT_EN
  logic [31:0] cycle;

  always_ff @(posedge clk) begin
    if (rst) cycle <= '0;
    else cycle <= cycle + 32'd1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (a_first) $display("[%0d] A opcode=%0d source=%0d", cycle, a_opcode, a_source);
      if (c_first) $display("[%0d] C opcode=%0d source=%0d", cycle, c_opcode, c_source);
      if (d_first) $display("[%0d] D opcode=%0d source=%0d sink=%0d", cycle, d_opcode, d_source, d_sink);
      if (err_valid) $display("[%0d] protocol error code=%0d", cycle, err_code);
    end
  end
`else
  logic unused_print;
  assign unused_print = d_first;
`endif

endmodule

// File: tb/tb_tl_protocol_checker.sv
// Directed bench for tl_protocol_checker: error codes go through a scoreboard queue,
// counters and pending state are checked against hand-computed values.

module tb_tl_protocol_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready;
  logic [2:0]  a_opcode, c_opcode, d_opcode;
  logic [3:0]  a_size, c_size, d_size;
  logic [3:0]  a_source, c_source, d_source, d_sink, e_sink;
  logic [63:0] a_address, c_address;
  logic        err_valid, err_sticky;
  logic [2:0]  err_code;
  logic [15:0] err_count, a_req_count, d_rsp_count;
  logic [4:0]  outstanding;

  int         n_checks = 0;
  int         n_fail = 0;
  int         model_errs = 0;
  logic [2:0] exp_q[$];

  tl_protocol_checker #(
    .ADDR_W(64), .DATA_W(64), .SOURCE_W(4), .SINK_W(4), .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_size(c_size),
    .c_source(c_source), .c_address(c_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink),
    .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky), .err_count(err_count),
    .a_req_count(a_req_count), .d_rsp_count(d_rsp_count), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setA(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [63:0] addr);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
  endtask

  task automatic setC(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [63:0] addr);
    c_valid = 1'b1; c_opcode = op; c_size = sz; c_source = src; c_address = addr;
  endtask

  task automatic setD(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [3:0] snk);
    d_valid = 1'b1; d_opcode = op; d_size = sz; d_source = src; d_sink = snk;
  endtask

  task automatic setE(input logic [3:0] snk);
    e_valid = 1'b1; e_sink = snk;
  endtask

  // One clock edge samples whatever is driven, then valids drop and ready returns high.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    a_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0; e_valid = 1'b0; d_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic dBeats(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                        input logic [3:0] snk, input int n, input int bad_beat, input logic [3:0] bad_src);
    for (int b = 0; b < n; b++) begin
      setD(op, sz, (b == bad_beat) ? bad_src : src, snk);
      applyStimulus();
    end
  endtask

  task automatic cBeats(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                        input logic [63:0] addr, input int bad_beat);
    for (int b = 0; b < 8; b++) begin
      setC(op, sz, src, (b == bad_beat) ? addr + 64'h40 : addr);
      applyStimulus();
    end
  endtask

  // Monitor: each error pulse pops the next expected code.
  initial begin
    logic [2:0] exp_code;
    forever begin
      @(negedge clk);
      if (!rst && err_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_err: got code %0d, expected no error pulse", err_code);
        end else begin
          exp_code = exp_q.pop_front();
          model_errs++;
          checkOutput("sb_err_code", 64'(err_code), 64'(exp_code));
          checkOutput("sb_err_count", 64'(err_count), 64'(model_errs));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL sim_timeout: got no end of test, expected $finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; c_valid = 0; d_valid = 0; e_valid = 0;
    a_ready = 1; c_ready = 1; d_ready = 1; e_ready = 1;
    a_opcode = 0; a_size = 0; a_source = 0; a_address = 0;
    c_opcode = 0; c_size = 0; c_source = 0; c_address = 0;
    d_opcode = 0; d_size = 0; d_source = 0; d_sink = 0; e_sink = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_err_valid", 64'(err_valid), 0);
    checkOutput("rst_err_code", 64'(err_code), 0);
    checkOutput("rst_err_sticky", 64'(err_sticky), 0);
    checkOutput("rst_err_count", 64'(err_count), 0);
    checkOutput("rst_a_req", 64'(a_req_count), 0);
    checkOutput("rst_d_rsp", 64'(d_rsp_count), 0);
    checkOutput("rst_outstanding", 64'(outstanding), 0);
    rst = 1'b0;

    // Get src3, then 8-beat AccessAckData with a stalled cycle before it
    setA(3'd4, 4'd6, 4'd3, 64'h1000); applyStimulus();
    checkOutput("get_a_req", 64'(a_req_count), 1);
    checkOutput("get_outstanding", 64'(outstanding), 1);
    setD(3'd1, 4'd6, 4'd3, 4'd0); d_ready = 1'b0; applyStimulus();
    checkOutput("stall_d_rsp", 64'(d_rsp_count), 0);
    dBeats(3'd1, 4'd6, 4'd3, 4'd0, 7, -1, 4'd0);
    checkOutput("beat7_outstanding", 64'(outstanding), 1);
    checkOutput("beat7_d_rsp", 64'(d_rsp_count), 0);
    dBeats(3'd1, 4'd6, 4'd3, 4'd0, 1, -1, 4'd0);
    checkOutput("beat8_outstanding", 64'(outstanding), 0);
    checkOutput("beat8_d_rsp", 64'(d_rsp_count), 1);
    checkOutput("clean_err_count", 64'(err_count), 0);

    // AcquireBlock src1 twice -> E_DUP_SRC
    setA(3'd6, 4'd6, 4'd1, 64'h2000); applyStimulus();
    checkOutput("acq_outstanding", 64'(outstanding), 1);
    exp_q.push_back(3'd2);
    setA(3'd6, 4'd6, 4'd1, 64'h2000); applyStimulus();
    checkOutput("dup_err_valid", 64'(err_valid), 1);
    checkOutput("dup_err_code", 64'(err_code), 2);
    checkOutput("dup_err_sticky", 64'(err_sticky), 1);
    checkOutput("dup_a_req", 64'(a_req_count), 3);
    idle(1);
    checkOutput("dup_pulse_width", 64'(err_valid), 0);

    // GrantData src1 sink2 with source glitch on beat 4, then E sink2 twice
    exp_q.push_back(3'd1);
    dBeats(3'd5, 4'd6, 4'd1, 4'd2, 8, 3, 4'd7);
    checkOutput("grant_d_rsp", 64'(d_rsp_count), 2);
    checkOutput("grant_outstanding", 64'(outstanding), 0);
    checkOutput("grant_err_code", 64'(err_code), 1);
    setE(4'd2); applyStimulus();
    exp_q.push_back(3'd4);
    setE(4'd2); applyStimulus();
    checkOutput("bad_sink_err_code", 64'(err_code), 4);
    checkOutput("bad_sink_err_count", 64'(err_count), 3);
    idle(2);

    // Watchdog: Get src0 with no D for two timeout periods
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd5);
    setA(3'd4, 4'd2, 4'd0, 64'h3000); applyStimulus();
    idle(15);
    checkOutput("wd_before_timeout", 64'(err_valid), 0);
    idle(1);
    checkOutput("wd_first_pulse", 64'(err_valid), 1);
    checkOutput("wd_first_code", 64'(err_code), 5);
    idle(16);
    checkOutput("wd_second_pulse", 64'(err_valid), 1);
    setD(3'd0, 4'd2, 4'd0, 4'd0); applyStimulus();
    checkOutput("wd_end_outstanding", 64'(outstanding), 0);
    checkOutput("wd_end_d_rsp", 64'(d_rsp_count), 3);
    checkOutput("wd_end_err_count", 64'(err_count), 5);
    idle(20);

    // Same-cycle D clear and A set on src5
    setA(3'd4, 4'd2, 4'd5, 64'h5000); applyStimulus();
    checkOutput("same_pre_outstanding", 64'(outstanding), 1);
    setD(3'd0, 4'd2, 4'd5, 4'd0); setA(3'd4, 4'd2, 4'd5, 64'h5040); applyStimulus();
    checkOutput("same_outstanding", 64'(outstanding), 1);
    checkOutput("same_err_valid", 64'(err_valid), 0);
    checkOutput("same_a_req", 64'(a_req_count), 6);
    checkOutput("same_d_rsp", 64'(d_rsp_count), 4);
    setD(3'd0, 4'd2, 4'd5, 4'd0); applyStimulus();
    checkOutput("same_drain_outstanding", 64'(outstanding), 0);

    // ReleaseData / ReleaseAck pairing, C burst address change, orphan AccessAck
    cBeats(3'd7, 4'd6, 4'd2, 64'h6000, -1);
    setD(3'd6, 4'd0, 4'd2, 4'd0); applyStimulus();
    exp_q.push_back(3'd3);
    setD(3'd6, 4'd0, 4'd2, 4'd0); applyStimulus();
    checkOutput("rel_noreq_code", 64'(err_code), 3);
    checkOutput("rel_d_rsp", 64'(d_rsp_count), 7);
    exp_q.push_back(3'd1);
    cBeats(3'd7, 4'd6, 4'd2, 64'h7000, 1);
    setD(3'd6, 4'd0, 4'd2, 4'd0); applyStimulus();
    exp_q.push_back(3'd3);
    setD(3'd0, 4'd2, 4'd9, 4'd0); applyStimulus();
    checkOutput("orphan_err_code", 64'(err_code), 3);
    checkOutput("orphan_d_rsp", 64'(d_rsp_count), 9);
    idle(3);

    checkOutput("final_err_count", 64'(err_count), 8);
    checkOutput("final_err_sticky", 64'(err_sticky), 1);
    checkOutput("exp_queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
